// File: rtl/vpe_vrf.sv
// VPE vector register file: masked / saturating-accumulate writeback, pending scoreboard, one registered read per cycle.
// Read latency 1 cycle; reads stall (rd_ready low) while the target is pending or being written this cycle.
`timescale 1ns/1ps

module vpe_vrf #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 64,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_v,
  input  logic [IDX_W-1:0]  wb_rf_idx,
  input  logic [1:0]        wb_rf_mux,
  input  logic              rsv_v,
  input  logic [IDX_W-1:0]  rsv_idx,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_v,
  output logic [DEPTH-1:0]  pending
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int HALF  = DATA_W / 2;

  localparam logic [1:0] MUX_FULL = 2'b00;
  localparam logic [1:0] MUX_LO   = 2'b01;
  localparam logic [1:0] MUX_HI   = 2'b10;

  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] acc_val;
  logic [DATA_W-1:0] wr_val;
  logic [DEPTH-1:0]  set_mask;
  logic [DEPTH-1:0]  clr_mask;
  logic              rd_collide;

  assign wr_old = regs[wb_rf_idx];

  // Per-lane signed add in LANE_W+1 bits; the two top bits disagree exactly on overflow.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    logic [LANE_W:0]   sum;

    assign a   = wr_old[i*LANE_W +: LANE_W];
    assign b   = wb_data[i*LANE_W +: LANE_W];
    assign sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};

    assign acc_val[i*LANE_W +: LANE_W] =
        (sum[LANE_W] != sum[LANE_W-1]) ? (sum[LANE_W] ? LANE_MIN : LANE_MAX)
                                       : sum[LANE_W-1:0];
  end

  always_comb begin
    wr_val = wr_old;
    case (wb_rf_mux)
      MUX_FULL: wr_val = wb_data;
      MUX_LO:   wr_val[HALF-1:0] = wb_data[HALF-1:0];
      MUX_HI:   wr_val[DATA_W-1:HALF] = wb_data[DATA_W-1:HALF];
      default:  wr_val = acc_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_v) begin
      regs[wb_rf_idx] <= wr_val;
    end
  end

  // Set is applied after clear so a same-cycle reservation survives its own writeback.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_v) begin
      set_mask[rsv_idx] = 1'b1;
    end
    if (wb_v) begin
      clr_mask[wb_rf_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // No bypass: a read hitting this cycle's write waits one cycle and sees the new value.
  assign rd_collide = wb_v && (wb_rf_idx == rd_idx);
  assign rd_ready   = rd_req && !pending[rd_idx] && !rd_collide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      rd_data_v <= 1'b0;
    end else begin
      rd_data_v <= rd_ready;
      if (rd_ready) begin
        rd_data <= regs[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_vpe_vrf.sv
// Self-checking bench for vpe_vrf: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps

module tb_vpe_vrf;

  logic        clk;
  logic        rst;
  logic [63:0] wb_data;
  logic        wb_v;
  logic [4:0]  wb_rf_idx;
  logic [1:0]  wb_rf_mux;
  logic        rsv_v;
  logic [4:0]  rsv_idx;
  logic        rd_req;
  logic [4:0]  rd_idx;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_data_v;
  logic [31:0] pending;

  vpe_vrf #(.DEPTH(32), .IDX_W(5), .DATA_W(64), .LANE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_data   (wb_data),
    .wb_v      (wb_v),
    .wb_rf_idx (wb_rf_idx),
    .wb_rf_mux (wb_rf_mux),
    .rsv_v     (rsv_v),
    .rsv_idx   (rsv_idx),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_data_v (rd_data_v),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_regs [32];
  logic [31:0] m_pend;
  logic [63:0] m_rd_data;
  logic        last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat_acc(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s = int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] apply_wr(input logic [63:0] old, input logic [63:0] d,
                                           input logic [1:0] mode);
    case (mode)
      2'd0:    return d;
      2'd1:    return {old[63:32], d[31:0]};
      2'd2:    return {d[63:32], old[31:0]};
      default: return sat_acc(old, d);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend    = '0;
    m_rd_data = '0;
  endtask

  task automatic drive(input logic wv, input logic [1:0] mux, input logic [4:0] widx,
                       input logic [63:0] wdat, input logic rv, input logic [4:0] ridx,
                       input logic rq, input logic [4:0] qidx);
    wb_v = wv; wb_rf_mux = mux; wb_rf_idx = widx; wb_data = wdat;
    rsv_v = rv; rsv_idx = ridx;
    rd_req = rq; rd_idx = qidx;
  endtask

  // One clock: check rd_ready before the edge, advance the model, check registered outputs after.
  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = rd_req && !m_pend[rd_idx] && !(wb_v && wb_rf_idx == rd_idx);
    chk("rd_ready", {63'd0, rd_ready}, {63'd0, exp_rdy});
    last_rdy = rd_ready;
    if (exp_rdy) m_rd_data = m_regs[rd_idx];
    if (wb_v) begin
      m_regs[wb_rf_idx]  = apply_wr(m_regs[wb_rf_idx], wb_data, wb_rf_mux);
      m_pend[wb_rf_idx]  = 1'b0;
    end
    if (rsv_v) m_pend[rsv_idx] = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_data_v", {63'd0, rd_data_v}, {63'd0, exp_rdy});
    chk("rd_data", rd_data, m_rd_data);
    chk("pending", {32'd0, pending}, {32'd0, m_pend});
  endtask

  task automatic idle();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 0, 5'd0);
  endtask

  logic        rq;
  logic [4:0]  qidx;

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    last_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_rd_data_v", {63'd0, rd_data_v}, 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_pending", {32'd0, pending}, 64'd0);

    // Read after reset
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd3); step();
    chk("rd3_after_reset", rd_data, 64'h0);

    // Full, low-half, high-half writes
    drive(1, 2'd0, 5'd5, 64'h0807060504030201, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd5); step();
    chk("wr_full", rd_data, 64'h0807060504030201);
    drive(1, 2'd1, 5'd5, 64'hFFFFFFFFFFFFFFFF, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd5); step();
    chk("wr_low", rd_data, 64'h08070605FFFFFFFF);
    drive(1, 2'd2, 5'd5, 64'hAAAAAAAA00000000, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd5); step();
    chk("wr_high", rd_data, 64'hAAAAAAAAFFFFFFFF);

    // Saturating accumulate: +sat, -sat, plain add
    drive(1, 2'd0, 5'd2, 64'h7F80101000000000, 0, 5'd0, 0, 5'd0); step();
    drive(1, 2'd3, 5'd2, 64'h01FF050500000000, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd2); step();
    chk("wr_acc", rd_data, 64'h7F80151500000000);

    // RAW hazard on register 7
    drive(0, 2'd0, 5'd0, 64'd0, 1, 5'd7, 0, 5'd0); step();
    chk("haz_pend_set", {63'd0, pending[7]}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd7); step();
      chk("haz_stall_pending", {63'd0, last_rdy}, 64'd0);
    end
    drive(1, 2'd0, 5'd7, 64'h1122334455667788, 0, 5'd0, 1, 5'd7); step();
    chk("haz_stall_wb", {63'd0, last_rdy}, 64'd0);
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd7); step();
    chk("haz_accept", {63'd0, last_rdy}, 64'd1);
    chk("haz_data", rd_data, 64'h1122334455667788);
    chk("haz_pend_clr", {63'd0, pending[7]}, 64'd0);

    // Reserve and writeback of register 9 together: set wins, write still lands
    drive(1, 2'd0, 5'd9, 64'hCAFEF00DDEADBEEF, 1, 5'd9, 0, 5'd0); step();
    chk("rsv_wb_pend", {63'd0, pending[9]}, 64'd1);
    drive(1, 2'd2, 5'd9, 64'h1234567800000000, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd9); step();
    chk("rsv_wb_data", rd_data, 64'h12345678DEADBEEF);

    // Read and reserve of the same register in one cycle: read wins with old value
    drive(0, 2'd0, 5'd0, 64'd0, 1, 5'd5, 1, 5'd5); step();
    chk("rd_rsv_same", rd_data, 64'hAAAAAAAAFFFFFFFF);
    drive(1, 2'd0, 5'd5, 64'd0, 0, 5'd0, 0, 5'd0); step();

    // Random traffic over a small index window to force collisions
    rq = 1'b0; qidx = 5'd0;
    for (int n = 0; n < 400; n++) begin
      if (!rq || last_rdy) begin
        rq   = ($urandom_range(0, 2) != 0);
        qidx = 5'($urandom_range(0, 7));
      end
      drive(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
            rq, qidx);
      step();
    end

    // Reset in the middle of a read
    drive(1, 2'd0, 5'd5, 64'h5555AAAA5555AAAA, 0, 5'd0, 0, 5'd0); step();
    drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'd5); step();
    chk("pre_rst_rd_v", {63'd0, rd_data_v}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_rd_data_v", {63'd0, rd_data_v}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_pending", {32'd0, pending}, 64'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      drive(0, 2'd0, 5'd0, 64'd0, 0, 5'd0, 1, 5'(i)); step();
      chk("rst_reg_zero", rd_data, 64'd0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
